// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory subsystem: MMIO map, FSM states, lane helper.
package arm_mem_pkg;

  localparam logic [15:0] GPO_OFS    = 16'h0000;
  localparam logic [15:0] CYCLE_OFS  = 16'h0040;
  localparam logic [15:0] STATUS_OFS = 16'h0044;
  localparam logic [3:0]  BE_WORD    = 4'hF;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int l = 0; l < 4; l++)
      if (be[l]) res[8*l +: 8] = wdata[8*l +: 8];
    return res;
  endfunction

endpackage

// File: rtl/arm_mmio_regs.sv
// MMIO register bank: byte-enabled GPO registers, free-running cycle counter, sticky error.
module arm_mmio_regs
  import arm_mem_pkg::*;
#(
  parameter int NUM_GPO = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [13:0]            word,
  input  logic [31:0]            wdata,
  input  logic                   set_err,
  output logic [31:0]            rdata,
  output logic [32*NUM_GPO-1:0]  gpo,
  output logic                   err
);

  localparam logic [13:0] GPO_W    = GPO_OFS[15:2];
  localparam logic [13:0] CYCLE_W  = CYCLE_OFS[15:2];
  localparam logic [13:0] STATUS_W = STATUS_OFS[15:2];

  logic [31:0] gpo_r [NUM_GPO];
  logic [31:0] cycle;
  logic        err_r;
  logic        clr_err;

  assign clr_err = sel && we && (word == STATUS_W) && be[0] && wdata[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPO; i++) gpo_r[i] <= '0;
      cycle <= '0;
      err_r <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      for (int i = 0; i < NUM_GPO; i++)
        if (sel && we && (word == GPO_W + 14'(i)))
          gpo_r[i] <= merge_lanes(gpo_r[i], wdata, be);
      // A fresh error outranks a clear landing in the same cycle.
      if (set_err)      err_r <= 1'b1;
      else if (clr_err) err_r <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_GPO; i++)
      if (word == GPO_W + 14'(i)) rdata = gpo_r[i];
    if (word == CYCLE_W)  rdata = cycle;
    if (word == STATUS_W) rdata = {31'b0, err_r};
  end

  for (genvar g = 0; g < NUM_GPO; g++) begin : g_gpo
    assign gpo[32*g +: 32] = gpo_r[g];
  end

  assign err = err_r;

endmodule

// File: rtl/arm_mem_subsys.sv
// Memory subsystem for the single-cycle ARM core: instruction ROM, wait-stated data RAM, MMIO bank.
module arm_mem_subsys
  import arm_mem_pkg::*;
#(
  parameter int          IMEM_WORDS  = 64,
  parameter int          DMEM_WORDS  = 64,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          NUM_GPO     = 2,
  parameter string       IMEM_FILE   = "imem.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            PC,
  output logic [31:0]            Instr,
  input  logic                   DReq,
  input  logic                   MemWrite,
  input  logic [3:0]             ByteEn,
  input  logic [31:0]            DataAdr,
  input  logic [31:0]            WriteData,
  output logic [31:0]            ReadData,
  output logic                   DReady,
  output logic                   Stall,
  output logic [32*NUM_GPO-1:0]  GPO,
  output logic                   Err
);

  localparam int          IMEM_AW    = $clog2(IMEM_WORDS);
  localparam int          DMEM_AW    = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [2:0]  WS         = 3'(WAIT_STATES);

  logic [31:0] rom [IMEM_WORDS];
  logic [31:0] ram [DMEM_WORDS];

  assign Instr = (PC < IMEM_BYTES) ? rom[PC[IMEM_AW+1:2]] : 32'h0;

  mem_state_t state;
  logic [2:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (DReq && WAIT_STATES != 0) begin
          state <= WAIT;
          cnt   <= 3'd1;
        end
        WAIT: if (!DReq || cnt == WS) begin
          // A dropped request abandons the access without committing.
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign DReady = DReq && (((state == IDLE) && (WAIT_STATES == 0)) ||
                           ((state == WAIT) && (cnt == WS)));
  assign Stall  = DReq && !DReady;

  logic        commit, in_mmio, in_ram, misalign, bad;
  logic [13:0] mmio_word;
  logic [31:0] mmio_rdata, sel_rdata;
  logic [DMEM_AW-1:0] ram_idx;

  assign commit    = DReq && DReady;
  assign in_mmio   = DataAdr >= MMIO_BASE;
  assign in_ram    = DataAdr < DMEM_BYTES;
  assign misalign  = (ByteEn == BE_WORD) && (DataAdr[1:0] != 2'b00);
  assign bad       = misalign || (!in_mmio && !in_ram);
  assign mmio_word = 14'((DataAdr - MMIO_BASE) >> 2);
  assign ram_idx   = DataAdr[DMEM_AW+1:2];

  // RAM is never reset; writes are held off while reset is asserted.
  always_ff @(posedge clk)
    if (commit && MemWrite && in_ram && !in_mmio && !misalign && !reset)
      ram[ram_idx] <= merge_lanes(ram[ram_idx], WriteData, ByteEn);

  arm_mmio_regs #(.NUM_GPO(NUM_GPO)) u_mmio (
    .clk     (clk),
    .rst     (reset),
    .sel     (commit && in_mmio && !misalign),
    .we      (MemWrite),
    .be      (ByteEn),
    .word    (mmio_word),
    .wdata   (WriteData),
    .set_err (commit && bad),
    .rdata   (mmio_rdata),
    .gpo     (GPO),
    .err     (Err)
  );

  always_comb begin
    sel_rdata = '0;
    if (in_mmio)     sel_rdata = mmio_rdata;
    else if (in_ram) sel_rdata = ram[ram_idx];
  end

  assign ReadData = (commit && !MemWrite && !bad) ? sel_rdata : 32'h0;

endmodule

// File: tb/tb_arm_mem_subsys.sv
// Self-checking bench: zero-wait instance against a reference model, three-wait instance for timing/reset.
module tb_arm_mem_subsys;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst0, rst3, DReq0, DReq3;
  logic [31:0] PC, DataAdr, WriteData;
  logic        MemWrite;
  logic [3:0]  ByteEn;
  logic [31:0] Instr0, Instr3, ReadData0, ReadData3;
  logic        DReady0, DReady3, Stall0, Stall3, Err0, Err3;
  logic [63:0] GPO0, GPO3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arm_mem_subsys #(.WAIT_STATES(0), .IMEM_FILE("")) dut0 (
    .clk(clk), .reset(rst0), .PC(PC), .Instr(Instr0), .DReq(DReq0), .MemWrite(MemWrite),
    .ByteEn(ByteEn), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData0),
    .DReady(DReady0), .Stall(Stall0), .GPO(GPO0), .Err(Err0));

  arm_mem_subsys #(.WAIT_STATES(3), .IMEM_FILE("")) dut3 (
    .clk(clk), .reset(rst3), .PC(PC), .Instr(Instr3), .DReq(DReq3), .MemWrite(MemWrite),
    .ByteEn(ByteEn), .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData3),
    .DReady(DReady3), .Stall(Stall3), .GPO(GPO3), .Err(Err3));

  // Clocks elapsed since each instance left reset: the expected CYCLE value.
  logic [31:0] cyc0, cyc3;
  always @(posedge clk or posedge rst0) if (rst0) cyc0 <= '0; else cyc0 <= cyc0 + 1;
  always @(posedge clk or posedge rst3) if (rst3) cyc3 <= '0; else cyc3 <= cyc3 + 1;

  // Reference state for dut0.
  logic [31:0] ram_m [64];
  logic [31:0] gpo_m [2];
  logic        err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Performs one access; returns number of stall cycles, read data and the expected CYCLE at completion.
  task automatic acc(input int which, input logic we, input logic [3:0] be,
                     input logic [31:0] adr, input logic [31:0] wd,
                     output int stalls, output logic [31:0] rd, output logic [31:0] cyc_at);
    MemWrite = we; ByteEn = be; DataAdr = adr; WriteData = wd;
    if (which == 0) DReq0 = 1'b1; else DReq3 = 1'b1;
    stalls = 0; rd = '0; cyc_at = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (which == 0 ? DReady0 : DReady3) begin
        rd     = (which == 0) ? ReadData0 : ReadData3;
        cyc_at = (which == 0) ? cyc0 : cyc3;
        break;
      end
      stalls++;
      chk("stall_during_wait", 32'((which == 0) ? Stall0 : Stall3), 32'd1);
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int l = 0; l < 4; l++) if (b[l]) r[8*l +: 8] = w[8*l +: 8];
    return r;
  endfunction

  // Behavioural model of one committed access; returns the expected ReadData.
  function automatic logic [31:0] model(input logic we, input logic [3:0] be,
                                        input logic [31:0] adr, input logic [31:0] wd,
                                        input logic [31:0] cyc_at);
    logic        mis, is_mmio, is_ram, e, clr;
    logic [31:0] rd, ofs;
    mis     = (be == 4'hF) && (adr % 4 != 0);
    is_mmio = adr >= BASE;
    is_ram  = !is_mmio && adr < 256;
    e       = mis || (!is_mmio && !is_ram);
    ofs     = (adr - BASE) / 4;
    rd = 0; clr = 0;
    if (!e && !we) begin
      if (is_ram)           rd = ram_m[adr / 4];
      else if (ofs < 2)     rd = gpo_m[ofs];
      else if (ofs == 16)   rd = cyc_at;
      else if (ofs == 17)   rd = {31'b0, err_m};
    end
    if (!e && we) begin
      if (is_ram)           ram_m[adr / 4] = lanes(ram_m[adr / 4], wd, be);
      else if (ofs < 2)     gpo_m[ofs] = lanes(gpo_m[ofs], wd, be);
      else if (ofs == 17)   clr = be[0] && wd[0];
    end
    if (e) err_m = 1'b1; else if (clr) err_m = 1'b0;
    return rd;
  endfunction

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int          st;
    logic [31:0] rd, ca, expv, a, b, adr, wd;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ofs_list [7];

    tbl[0]  = '{1'b1, 4'hF, 32'h10,         32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'hF, 32'h10,         32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'h2, 32'h10,         32'h0000AA00, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 4'hF, 32'h10,         32'h0,        32'hDEADAAEF, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 32'h00,         32'h0BADF00D, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 4'hF, 32'h400,        32'h12345678, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 4'hF, 32'h00,         32'h0,        32'h0BADF00D, 1'b1};
    tbl[7]  = '{1'b1, 4'hF, 32'hFFFF_0044,  32'h1,        32'h0,        1'b0};
    tbl[8]  = '{1'b0, 4'hF, 32'hFFFF_0044,  32'h0,        32'h0,        1'b0};
    tbl[9]  = '{1'b1, 4'hF, 32'hFFFF_0045,  32'h1,        32'h0,        1'b1};
    tbl[10] = '{1'b0, 4'hF, 32'hFFFF_0044,  32'h0,        32'h1,        1'b1};
    tbl[11] = '{1'b1, 4'hF, 32'hFFFF_0044,  32'h1,        32'h0,        1'b0};
    tbl[12] = '{1'b1, 4'hF, 32'hFFFF_0004,  32'h5,        32'h0,        1'b0};
    tbl[13] = '{1'b0, 4'hF, 32'hFFFF_0004,  32'h0,        32'h5,        1'b0};
    tbl[14] = '{1'b1, 4'hF, 32'hFFFF_0040,  32'hAAAA,     32'h0,        1'b0};
    tbl[15] = '{1'b0, 4'hF, 32'hFFFF_0080,  32'h0,        32'h0,        1'b0};
    tbl[16] = '{1'b0, 4'hF, 32'h12,         32'h0,        32'h0,        1'b1};
    tbl[17] = '{1'b0, 4'hF, 32'h400,        32'h0,        32'h0,        1'b1};
    tbl[18] = '{1'b1, 4'h1, 32'hFFFF_0044,  32'h1,        32'h0,        1'b0};

    ofs_list = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48, 32'h80};

    rst0 = 1; rst3 = 1; DReq0 = 0; DReq3 = 0;
    PC = 0; MemWrite = 0; ByteEn = 0; DataAdr = 0; WriteData = 0;
    repeat (2) @(negedge clk);
    chk("reset_err", 32'(Err0), 0);
    chk("reset_gpo_lo", GPO0[31:0], 0);
    chk("reset_gpo_hi", GPO0[63:32], 0);
    chk("reset_dready", 32'(DReady0), 0);
    chk("reset_stall", 32'(Stall0), 0);
    chk("reset_rdata", ReadData0, 0);
    rst0 = 0; rst3 = 0;
    @(negedge clk);

    PC = 32'h100;
    #1 chk("instr_out_of_range", Instr0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      acc(0, tbl[i].we, tbl[i].be, tbl[i].adr, tbl[i].wd, st, rd, ca);
      chk($sformatf("tbl%0d_stalls", i), 32'(st), 0);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), 32'(Err0), 32'(tbl[i].err));
    end
    chk("gpo1_after_write", GPO0[63:32], 32'h5);
    chk("gpo0_untouched", GPO0[31:0], 32'h0);

    gpo_m[0] = 0; gpo_m[1] = 5; err_m = 0;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      ram_m[i] = wd;
      acc(0, 1'b1, 4'hF, 32'(i * 4), wd, st, rd, ca);
    end

    for (int n = 0; n < 300; n++) begin
      int k;
      k  = $urandom_range(0, 9);
      we = 1'($urandom);
      be = 4'($urandom);
      wd = $urandom;
      if (k < 5)       adr = $urandom_range(0, 255);
      else if (k == 5) adr = 32'h100 + ($urandom % 32'hFFFE_FF00);
      else if (k < 9)  adr = BASE + ofs_list[$urandom_range(0, 6)] + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 0);
      else begin adr = BASE + 32'h44; be = 4'hF; we = 1; wd = wd | 1; end
      acc(0, we, be, adr, wd, st, rd, ca);
      expv = model(we, be, adr, wd, ca);
      chk("rand_stalls", 32'(st), 0);
      chk("rand_rdata", rd, expv);
      chk("rand_err", 32'(Err0), 32'(err_m));
      chk("rand_gpo0", GPO0[31:0], gpo_m[0]);
      chk("rand_gpo1", GPO0[63:32], gpo_m[1]);
    end

    acc(0, 1'b0, 4'hF, BASE + 32'h40, 0, st, a, ca);
    DReq0 = 0;
    repeat (6) @(negedge clk);
    acc(0, 1'b0, 4'hF, BASE + 32'h40, 0, st, b, ca);
    chk("cycle_delta", b - a, 32'd7);

    DReq0 = 0;
    @(negedge clk);
    force dut0.u_mmio.cycle = 32'hFFFF_FFFF;
    #1 release dut0.u_mmio.cycle;
    acc(0, 1'b0, 4'hF, BASE + 32'h40, 0, st, rd, ca);
    chk("cycle_forced_max", rd, 32'hFFFF_FFFF);
    acc(0, 1'b0, 4'hF, BASE + 32'h40, 0, st, rd, ca);
    chk("cycle_wrap", rd, 32'h0);
    DReq0 = 0;

    acc(3, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, st, rd, ca);
    chk("w3_write_stalls", 32'(st), 3);
    acc(3, 1'b0, 4'hF, 32'h10, 0, st, rd, ca);
    chk("w3_b2b_read_stalls", 32'(st), 3);
    chk("w3_read_data", rd, 32'hDEADBEEF);
    acc(3, 1'b1, 4'hF, BASE, 32'h77, st, rd, ca);
    chk("w3_gpo_write", GPO3[31:0], 32'h77);
    acc(3, 1'b1, 4'hF, 32'h400, 32'h1, st, rd, ca);
    chk("w3_hole_err", 32'(Err3), 1);
    acc(3, 1'b1, 4'hF, 32'h20, 32'h11223344, st, rd, ca);
    DReq3 = 0;
    @(negedge clk);

    MemWrite = 1; ByteEn = 4'hF; DataAdr = 32'h20; WriteData = 32'h55667788; DReq3 = 1;
    repeat (2) @(negedge clk);
    #1 rst3 = 1;
    #1;
    chk("rst_mid_gpo", GPO3[31:0], 0);
    chk("rst_mid_err", 32'(Err3), 0);
    chk("rst_mid_dready", 32'(DReady3), 0);
    DReq3 = 0;
    #1 rst3 = 0;
    @(negedge clk);
    acc(3, 1'b0, 4'hF, BASE + 32'h40, 0, st, rd, ca);
    chk("rst_idle_stalls", 32'(st), 3);
    chk("rst_cycle_restart", rd, 32'd4);
    acc(3, 1'b0, 4'hF, 32'h20, 0, st, rd, ca);
    chk("rst_ram_unchanged", rd, 32'h11223344);
    DReq3 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
